// File: rtl/agc_isa_pkg.sv
// Shared AGC instruction-set constants, field positions and the legality rule
// used by the instruction decoder.
package agc_isa_pkg;

   localparam int WORD_W = 15;
   localparam int ADDR_W = 12;

   localparam int OPCODE_MSB = 14;
   localparam int OPCODE_LSB = 12;
   localparam int QC_MSB     = 11;
   localparam int QC_LSB     = 10;
   localparam int ADDR_MSB   = 11;
   localparam int ADDR_LSB   = 0;

   localparam logic [2:0] OP_TC   = 3'd0;
   localparam logic [2:0] OP_CCS  = 3'd1;
   localparam logic [2:0] OP_CS   = 3'd4;
   localparam logic [2:0] OP_QC5  = 3'd5;
   localparam logic [2:0] OP_AD   = 3'd6;
   localparam logic [2:0] OP_MASK = 3'd7;

   localparam logic [1:0] QC_INDEX  = 2'd0;
   localparam logic [1:0] QC_EXTEND = 2'd1;
   localparam logic [1:0] QC_TS     = 2'd2;
   localparam logic [1:0] QC_XCH    = 2'd3;

   // Opcodes 2 and 3 have no sequencer state; under EXTEND, opcodes 0/4/5
   // are only defined for quarter-code 1.
   function automatic logic is_legal(input logic [2:0] op,
                                     input logic [1:0] qc,
                                     input logic       ext);
      logic no_state;
      logic bad_extra;
      no_state  = (op == 3'd2) || (op == 3'd3);
      bad_extra = ext && (op == OP_TC || op == OP_CS || op == OP_QC5) &&
                  (qc != QC_EXTEND);
      return !(no_state || bad_extra);
   endfunction

endpackage

// File: rtl/agc_instr_decoder_if.sv
// Fetch/index/sequencer bundle between the instruction decoder (master) and
// its surroundings (slave: fetch path, INDEX unit and control-pulse sequencer).
interface agc_instr_decoder_if;
   import agc_isa_pkg::*;

   logic              instr_valid;
   logic [WORD_W-1:0] instr_word;
   logic              instr_ready;
   logic              index_load;
   logic [WORD_W-1:0] index_val;
   logic              dec_valid;
   logic              seq_ack;
   logic [2:0]        opcode;
   logic [1:0]        qc;
   logic              extracode;
   logic [ADDR_W-1:0] addr;
   logic              illegal;

   modport master (
      input  instr_valid, instr_word, index_load, index_val, seq_ack,
      output instr_ready, dec_valid, opcode, qc, extracode, addr, illegal
   );

   modport slave (
      output instr_valid, instr_word, index_load, index_val, seq_ack,
      input  instr_ready, dec_valid, opcode, qc, extracode, addr, illegal
   );

endinterface

// File: rtl/agc_field_decode.sv
// Combinational split of an (index-adjusted) instruction word into opcode,
// quarter-code and address fields plus the illegal-combination flag.
module agc_field_decode
   import agc_isa_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic              ext,
   output logic [2:0]        opcode,
   output logic [1:0]        qc,
   output logic [ADDR_W-1:0] addr,
   output logic              illegal
);

   assign opcode  = word[OPCODE_MSB:OPCODE_LSB];
   assign qc      = word[QC_MSB:QC_LSB];
   assign addr    = word[ADDR_MSB:ADDR_LSB];
   assign illegal = !is_legal(word[OPCODE_MSB:OPCODE_LSB],
                              word[QC_MSB:QC_LSB], ext);

endmodule

// File: rtl/agc_instr_decoder.sv
// Instruction decoder: captures a fetched word, applies a pending INDEX offset,
// tracks the EXTEND latch and holds the decode until the sequencer acks.
// Optional retire statistics enabled by defining AGC_DEC_STATS_EN.
module agc_instr_decoder
   import agc_isa_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   agc_instr_decoder_if.master bus
`ifdef AGC_DEC_STATS_EN
   ,
   output logic [15:0]        retired_cnt,
   output logic [WORD_W-1:0]  last_word
`endif
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_VALID = 1'b1;

   logic [0:0]        state_q,      state_d;
   logic [2:0]        opcode_q,     opcode_d;
   logic [1:0]        qc_q,         qc_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              extracode_q,  extracode_d;
   logic              illegal_q,    illegal_d;
   logic              ext_latch_q,  ext_latch_d;
   logic              idx_pend_q,   idx_pend_d;
   logic [WORD_W-1:0] idx_reg_q,    idx_reg_d;

   logic [WORD_W-1:0] cap_word;
   logic [2:0]        dec_opcode;
   logic [1:0]        dec_qc;
   logic [ADDR_W-1:0] dec_addr;
   logic              dec_illegal;
   logic              capture;
   logic              ack;

   // Index offset wraps modulo 2^WORD_W, matching one's-complement-free adder.
   assign cap_word = bus.instr_word + (idx_pend_q ? idx_reg_q : '0);
   assign capture  = (state_q == ST_EMPTY) && bus.instr_valid;
   assign ack      = (state_q == ST_VALID) && bus.seq_ack;

   agc_field_decode u_field_decode (
      .word    (cap_word),
      .ext     (ext_latch_q),
      .opcode  (dec_opcode),
      .qc      (dec_qc),
      .addr    (dec_addr),
      .illegal (dec_illegal)
   );

   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      qc_d        = qc_q;
      addr_d      = addr_q;
      extracode_d = extracode_q;
      illegal_d   = illegal_q;
      ext_latch_d = ext_latch_q;
      idx_pend_d  = idx_pend_q;
      idx_reg_d   = idx_reg_q;

      if (capture) begin
         state_d     = ST_VALID;
         opcode_d    = dec_opcode;
         qc_d        = dec_qc;
         addr_d      = dec_addr;
         extracode_d = ext_latch_q;
         illegal_d   = dec_illegal;
         idx_pend_d  = 1'b0;
      end

      if (ack) begin
         state_d     = ST_EMPTY;
         ext_latch_d = (opcode_q == OP_QC5) && (qc_q == QC_EXTEND);
      end

      // A load in the capture cycle must survive the clear above.
      if (bus.index_load) begin
         idx_reg_d  = bus.index_val;
         idx_pend_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         opcode_q    <= '0;
         qc_q        <= '0;
         addr_q      <= '0;
         extracode_q <= 1'b0;
         illegal_q   <= 1'b0;
         ext_latch_q <= 1'b0;
         idx_pend_q  <= 1'b0;
         idx_reg_q   <= '0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         qc_q        <= qc_d;
         addr_q      <= addr_d;
         extracode_q <= extracode_d;
         illegal_q   <= illegal_d;
         ext_latch_q <= ext_latch_d;
         idx_pend_q  <= idx_pend_d;
         idx_reg_q   <= idx_reg_d;
      end
   end

   assign bus.instr_ready = (state_q == ST_EMPTY);
   assign bus.dec_valid   = (state_q == ST_VALID);
   assign bus.opcode      = opcode_q;
   assign bus.qc          = qc_q;
   assign bus.addr        = addr_q;
   assign bus.extracode   = extracode_q;
   assign bus.illegal     = illegal_q;

`ifdef AGC_DEC_STATS_EN
   logic [WORD_W-1:0] held_word_q,   held_word_d;
   logic [15:0]       retired_cnt_q, retired_cnt_d;
   logic [WORD_W-1:0] last_word_q,   last_word_d;

   always_comb begin
      held_word_d   = held_word_q;
      retired_cnt_d = retired_cnt_q;
      last_word_d   = last_word_q;
      if (capture) held_word_d = cap_word;
      if (ack) begin
         retired_cnt_d = retired_cnt_q + 16'd1;
         last_word_d   = held_word_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         held_word_q   <= '0;
         retired_cnt_q <= '0;
         last_word_q   <= '0;
      end else begin
         held_word_q   <= held_word_d;
         retired_cnt_q <= retired_cnt_d;
         last_word_q   <= last_word_d;
      end
   end

   assign retired_cnt = retired_cnt_q;
   assign last_word   = last_word_q;
`endif

endmodule
